// File: rtl/ms_pkg.sv
// Shared multi-stream definitions: default widths and the tagged-word layout
// used by the merger, the multi-stream FIFO and their benches.
package ms_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_FLUX       = 2;
    localparam int unsigned DEF_ID_W       = $clog2(DEF_FLUX);

    typedef struct packed {
        logic [DEF_ID_W-1:0]       id;
        logic [DEF_DATA_WIDTH-1:0] data;
    } tagged_word_t;

    function automatic tagged_word_t pack_word(input logic [DEF_ID_W-1:0]       id,
                                               input logic [DEF_DATA_WIDTH-1:0] data);
        tagged_word_t w;
        w.id   = id;
        w.data = data;
        return w;
    endfunction

    function automatic logic [DEF_ID_W-1:0] word_id(input tagged_word_t w);
        return w.id;
    endfunction

    function automatic logic [DEF_DATA_WIDTH-1:0] word_data(input tagged_word_t w);
        return w.data;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted requester and
// wraps; the pointer advances only when the grant is taken.
module rr_arbiter
    import ms_pkg::*;
#(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          ack,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [IW-1:0] last_grant;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            logic [IW-1:0] j;
            j = IW'((32'(last_grant) + k) % N);
            if (!grant_valid && req[j]) begin
                grant_valid = 1'b1;
                grant_idx   = j;
            end
        end
        grant = grant_valid ? (N'(1) << grant_idx) : '0;
    end

    // Reset to N-1 so requester 0 has first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= IW'(N - 1);
        end else if (ack && grant_valid) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/ms_merge_rr.sv
// Multi-stream merger: round-robin pops FWFT source queues and writes one
// {id, data} word per cycle toward the multi-stream FIFO, honouring its full flags.
module ms_merge_rr
    import ms_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int unsigned FLUX       = DEF_FLUX,
    localparam int unsigned ID_W       = $clog2(FLUX)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FLUX*DATA_WIDTH-1:0] src_data,
    input  logic [FLUX-1:0]            src_empty,
    output logic [FLUX-1:0]            src_read,
    output logic [DATA_WIDTH+ID_W-1:0] dst_din,
    output logic                       dst_write,
    input  logic [FLUX-1:0]            dst_full
);

    logic [FLUX-1:0]       req;
    logic [FLUX-1:0]       pending;
    logic [FLUX-1:0]       grant;
    logic [ID_W-1:0]       grant_idx;
    logic                  grant_valid;
    logic [DATA_WIDTH-1:0] sel_data;

    // A write still in the output register is not yet reflected in dst_full,
    // so its flux sits out one cycle to protect the last free slot.
    assign pending = dst_write ? (FLUX'(1) << dst_din[DATA_WIDTH +: ID_W]) : '0;
    assign req     = ~src_empty & ~dst_full & ~pending;

    rr_arbiter #(.N(FLUX)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .ack         (grant_valid),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign src_read = rst ? '0 : grant;
    assign sel_data = src_data[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

    // Output register; dst_din holds its last value when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_write <= 1'b0;
            dst_din   <= '0;
        end else begin
            dst_write <= grant_valid;
            if (grant_valid) begin
                dst_din <= {grant_idx, sel_data};
            end
        end
    end

endmodule
